// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: sizes, sample type, loader states
// and the 3-bit index reversal used to feed decimation-in-time cores.
package fft_pkg;

  localparam int FFT_N    = 32;
  localparam int FFT_LEN  = 8;
  localparam int FFT_LOG2 = 3;

  typedef logic signed [FFT_N-1:0] sample_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-stream and frame handshake bundle between the serial source, the frame
// loader and the combinational FFT consumer.
interface fft_frame_loader_if #(
  parameter int N = 32
);

  logic                s_valid;
  logic                s_ready;
  logic                s_first;
  logic signed [N-1:0] s_data;

  logic signed [N-1:0] f_0;
  logic signed [N-1:0] f_1;
  logic signed [N-1:0] f_2;
  logic signed [N-1:0] f_3;
  logic signed [N-1:0] f_4;
  logic signed [N-1:0] f_5;
  logic signed [N-1:0] f_6;
  logic signed [N-1:0] f_7;
  logic                frame_valid;
  logic                frame_ready;

  modport slave (
    input  s_valid, s_first, s_data, frame_ready,
    output s_ready, frame_valid, f_0, f_1, f_2, f_3, f_4, f_5, f_6, f_7
  );

  modport master (
    output s_valid, s_first, s_data, frame_ready,
    input  s_ready, frame_valid, f_0, f_1, f_2, f_3, f_4, f_5, f_6, f_7
  );

endinterface

// File: rtl/fft_frame_loader.sv
// Double-buffered serial-to-parallel loader building 8-sample frames for the FFT.
// Define FFT_FRAME_BITREV_EN to load the output bank in bit-reversed sample order.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fft_frame_loader_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [0:0] ST_FILL = FILL;
  localparam logic [0:0] ST_HOLD = HOLD;

  logic [0:0]          state;
  logic [2:0]          idx;
  logic                frame_valid;
  logic signed [N-1:0] fill      [FFT_LEN];
  logic signed [N-1:0] fill_next [FFT_LEN];
  logic signed [N-1:0] bank      [FFT_LEN];

  logic accept;
  logic resync;
  logic complete;
  logic out_free;
  logic handoff;
  logic transfer;

  assign bus.s_ready = !rst && (state == ST_FILL);
  assign accept      = bus.s_valid && bus.s_ready;
  assign resync      = accept && bus.s_first && (idx != 3'd0);
  assign complete    = accept && !resync && (idx == 3'(FFT_LEN - 1));
  assign out_free    = !frame_valid || bus.frame_ready;
  assign handoff     = frame_valid && bus.frame_ready;
  assign transfer    = ((state == ST_FILL) && complete && out_free) ||
                       ((state == ST_HOLD) && bus.frame_ready);

  // The bank loads from fill_next so the 8th sample reaches the output on its own accept edge.
  for (genvar k = 0; k < FFT_LEN; k++) begin : g_slot
    localparam logic [2:0] SLOT = 3'(k);
`ifdef FFT_FRAME_BITREV_EN
    localparam int SRC = int'(bitrev3(SLOT));
`else
    localparam int SRC = k;
`endif

    assign fill_next[k] = (accept && (resync ? (SLOT == 3'd0) : (idx == SLOT)))
                          ? bus.s_data : fill[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        fill[k] <= '0;
      end else begin
        fill[k] <= fill_next[k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        bank[k] <= '0;
      end else if (transfer) begin
        bank[k] <= fill_next[SRC];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      idx         <= 3'd0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      if (resync) begin
        idx <= 3'd1;
      end else if (accept) begin
        idx <= idx + 3'd1;
      end

      if ((state == ST_FILL) && complete && !out_free) begin
        state <= ST_HOLD;
      end else if ((state == ST_HOLD) && bus.frame_ready) begin
        state <= ST_FILL;
      end

      if (transfer) begin
        frame_valid <= 1'b1;
      end else if (handoff) begin
        frame_valid <= 1'b0;
      end

      if (handoff) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (resync) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign bus.frame_valid = frame_valid;
  assign bus.f_0 = bank[0];
  assign bus.f_1 = bank[1];
  assign bus.f_2 = bank[2];
  assign bus.f_3 = bank[3];
  assign bus.f_4 = bank[4];
  assign bus.f_5 = bank[5];
  assign bus.f_6 = bank[6];
  assign bus.f_7 = bank[7];

endmodule
